// File: rtl/counter_5bit_seq_ctrl.sv
// rtl/counter_5bit_seq_ctrl.sv - fill-then-drain sequencer driving a 5-bit occupancy counter
//
// Accepts a frame of up to DEPTH items from upstream (one counter increment per
// item), then releases them downstream (one decrement per item) until the
// counter reports zero, then pulses done.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               begin a frame (IDLE only)
//   abort               cancel the current frame (any state but IDLE)
//   in_valid, in_last   upstream item present / final item of frame
//   in_ready            item accepted this cycle
//   out_ready           downstream can take an item
//   out_valid           item offered downstream
//   cnt_value, down_done counter result / counter is zero
//   cntU, cntD, rst5    counter increment / decrement / synchronous clear
//   frame_len           items in the current or last completed frame
//   busy, done          not idle / one-cycle frame-drained pulse
module counter_5bit_seq_ctrl #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    input  logic [WIDTH-1:0] cnt_value,
    input  logic             down_done,
    output logic             cntU,
    output logic             cntD,
    output logic             rst5,
    output logic [WIDTH-1:0] frame_len,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_DRAIN,
        S_DONE,
        S_FLUSH
    } state_t;

    localparam logic [WIDTH-1:0] DEPTH_W  = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(DEPTH - 1);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            frame_len <= '0;
        end else begin
            state <= state_nxt;
            // frame_end already excludes abort cycles, so an aborted frame
            // never overwrites the previous length.
            if (frame_end) begin
                frame_len <= cnt_value + WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        cntU      = 1'b0;
        cntD      = 1'b0;
        rst5      = 1'b0;
        accept    = 1'b0;
        frame_end = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                rst5      = 1'b1;
                state_nxt = S_FILL;
            end
            S_FILL: begin
                // Blocking at DEPTH keeps the counter from wrapping.
                in_ready  = (cnt_value < DEPTH_W) && !abort;
                accept    = in_valid && in_ready;
                cntU      = accept;
                frame_end = accept && (in_last || (cnt_value == LAST_CNT));
                if (frame_end) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The counter updates one cycle after the strobe, so the
                // last decrement is followed by one empty DRAIN cycle.
                out_valid = !down_done && !abort;
                cntD      = out_valid && out_ready;
                if (down_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_FLUSH: begin
                rst5      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (abort && (state != S_IDLE)) begin
            state_nxt = S_FLUSH;
        end

        // Keep counter strobes and handshakes quiet while reset is applied.
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            cntU      = 1'b0;
            cntD      = 1'b0;
            rst5      = 1'b0;
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_counter_5bit_seq_ctrl.sv
// tb/tb_counter_5bit_seq_ctrl.sv - randomized self-checking bench for counter_5bit_seq_ctrl
module tb_counter_5bit_seq_ctrl;

    localparam int WIDTH = 5;
    localparam int DEPTH = 31;
    localparam int BUDGET = 2000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] cnt_value;
    logic             down_done;
    logic             cntU;
    logic             cntD;
    logic             rst5;
    logic [WIDTH-1:0] frame_len;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] cnt;

    int checks = 0;
    int errors = 0;
    int occ = 0;      // items held: accepted minus released
    int exp_len = 0;  // length of last completed frame
    bit toggle_ready;

    always #5 clk = ~clk;

    // Peer counter the sequencer drives; shares rst with the DUT.
    always @(posedge clk) begin
        if (rst || rst5)  cnt <= '0;
        else if (cntU)    cnt <= cnt + 1'b1;
        else if (cntD)    cnt <= cnt - 1'b1;
    end
    assign cnt_value = cnt;
    assign down_done = (cnt == '0);

    counter_5bit_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .cnt_value (cnt_value),
        .down_done (down_done),
        .cntU      (cntU),
        .cntD      (cntD),
        .rst5      (rst5),
        .frame_len (frame_len),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample;
        @(negedge clk);
        check("strobe_excl", 32'(cntU) + 32'(cntD) + 32'(rst5) <= 1, 1);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input bit hold_start);
        start = 1'b1;
        sample;
        check("idle_busy", busy, 0);
        check("idle_rst5", rst5, 0);
        check("idle_in_ready", in_ready, 0);
        next_cycle;
        if (!hold_start) start = 1'b0;
        sample;
        check("clear_rst5", rst5, 1);
        check("clear_busy", busy, 1);
        check("clear_in_ready", in_ready, 0);
        next_cycle;
        occ = 0;
    endtask

    // Offer items until the frame closes (in_last on item n, or DEPTH reached).
    // abort_after >= 0 cancels the frame once that many items are held.
    task automatic fill(input int n, input bit use_last, input int pv,
                        input int abort_after, input bit keep_valid);
        int  acc = 0;
        int  cyc = 0;
        bit  fin = 0;
        while (!fin) begin
            if (abort_after >= 0 && acc == abort_after) begin
                abort = 1'b1;
                in_valid = 1'b1;
                in_last = 1'b0;
                sample;
                check("abort_cnt", cnt, occ);
                check("abort_in_ready", in_ready, 0);
                check("abort_cntU", cntU, 0);
                check("abort_busy", busy, 1);
                next_cycle;
                abort = 1'b0;
                in_valid = 1'b0;
                sample;
                check("flush_rst5", rst5, 1);
                check("flush_done", done, 0);
                check("flush_in_ready", in_ready, 0);
                next_cycle;
                occ = 0;
                sample;
                check("post_flush_busy", busy, 0);
                check("post_flush_done", done, 0);
                check("post_flush_cnt", cnt, 0);
                check("post_flush_len", frame_len, exp_len);
                next_cycle;
                return;
            end
            in_valid = ($urandom_range(99) < pv);
            in_last  = in_valid ? (use_last && acc == n - 1) : 1'($urandom_range(1));
            sample;
            check("fill_in_ready", in_ready, 1);
            check("fill_cntU", cntU, in_valid);
            check("fill_out_valid", out_valid, 0);
            check("fill_cnt", cnt, occ);
            check("fill_len_hold", frame_len, exp_len);
            if (in_valid) begin
                acc++;
                occ++;
                if (in_last || occ == DEPTH) fin = 1;
            end
            next_cycle;
            cyc++;
            if (cyc > BUDGET) begin
                check("fill_timeout", 0, 1);
                return;
            end
        end
        if (!keep_valid) in_valid = 1'b0;
        in_last = 1'b0;
        exp_len = acc;
    endtask

    // Release items; pr < 0 alternates out_ready 1,0,1,0. stop_at >= 0
    // returns early while that many items are still held.
    task automatic drain(input int pr, input int stop_at);
        int cyc = 0;
        toggle_ready = 1'b0;
        while (occ > 0) begin
            if (stop_at >= 0 && occ == stop_at) return;
            if (pr < 0) begin
                toggle_ready = ~toggle_ready;
                out_ready = toggle_ready;
            end else begin
                out_ready = ($urandom_range(99) < pr);
            end
            sample;
            check("drain_out_valid", out_valid, 1);
            check("drain_cntD", cntD, out_ready);
            check("drain_in_ready", in_ready, 0);
            check("drain_cnt", cnt, occ);
            check("drain_len", frame_len, exp_len);
            if (out_ready) occ--;
            next_cycle;
            cyc++;
            if (cyc > BUDGET) begin
                check("drain_timeout", 0, 1);
                return;
            end
        end
        out_ready = 1'($urandom_range(1));
        sample;
        check("empty_out_valid", out_valid, 0);
        check("empty_cntD", cntD, 0);
        check("empty_cnt", cnt, 0);
        check("empty_done", done, 0);
        next_cycle;
        sample;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_len", frame_len, exp_len);
        check("done_out_valid", out_valid, 0);
        next_cycle;
        sample;
        check("done_clear", done, 0);
        check("idle_after_busy", busy, 0);
        check("idle_after_len", frame_len, exp_len);
        next_cycle;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) next_cycle;
        rst = 1'b0;
        sample;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_len", frame_len, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_rst5", rst5, 0);
        check("rst_cnt", cnt, 0);
        next_cycle;

        // 3-item frame, last on 3rd, downstream always ready
        begin_frame(0);
        fill(3, 1, 100, -1, 0);
        check("t1_len", exp_len, 3);
        drain(100, -1);

        // full frame without in_last; item 32 held upstream through drain
        begin_frame(0);
        fill(0, 0, 100, -1, 1);
        drain(100, -1);
        check("t2_len", frame_len, DEPTH);
        in_valid = 1'b0;

        // drain with out_ready alternating
        begin_frame(0);
        fill(7, 1, 100, -1, 0);
        drain(-1, -1);

        // abort in FILL once 5 items are held
        begin_frame(0);
        fill(20, 1, 100, 5, 0);

        // reset in DRAIN with 4 items held
        begin_frame(0);
        fill(6, 1, 100, -1, 0);
        drain(100, 4);
        rst = 1'b1;
        out_ready = 1'b1;
        sample;
        check("rst_mid_cntD", cntD, 0);
        check("rst_mid_out_valid", out_valid, 0);
        next_cycle;
        rst = 1'b0;
        out_ready = 1'b0;
        occ = 0;
        exp_len = 0;
        sample;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_len", frame_len, 0);
        check("rst_mid_cnt", cnt, 0);
        check("rst_mid_out_valid2", out_valid, 0);
        next_cycle;

        // start held high throughout a 1-item frame, then restarts from IDLE
        begin_frame(1);
        fill(1, 1, 100, -1, 0);
        drain(100, -1);
        sample;
        check("restart_rst5", rst5, 1);
        check("restart_busy", busy, 1);
        start = 1'b0;
        next_cycle;
        occ = 0;
        fill(2, 1, 80, -1, 0);
        drain(60, -1);

        // randomized frames
        for (int f = 0; f < 15; f++) begin
            begin_frame(0);
            fill($urandom_range(1, DEPTH), $urandom_range(3) != 0,
                 $urandom_range(30, 100), -1, 0);
            drain($urandom_range(30, 100), -1);
        end

        // randomized abort point
        begin_frame(0);
        fill(DEPTH, 0, 100, $urandom_range(0, 10), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
